// File: rtl/butterfly_decoder.sv
// Rebuilds W/X RAM contents from butterfly-encoded Y/Z RAMs, one word pair per clock, with LSB parity flagging.
// Latency: writes for pair k land RD_LAT+1 clocks after its reads; done_o pulses at T0+2+HALF+RD_LAT.
// No backpressure: RAM traffic runs at a fixed rate and start_i is ignored while busy_o is high.
module butterfly_decoder #(
    parameter int DATA_W = 8,
    parameter int HALF   = 256,
    parameter int ADDR_W = 9,
    parameter int RD_LAT = 1
) (
    input  logic              CLOCK_50_I,
    input  logic              resetn,
    input  logic              start_i,
    output logic              busy_o,
    output logic              done_o,
    output logic [ADDR_W-1:0] y_addr_a_o,
    output logic [ADDR_W-1:0] y_addr_b_o,
    input  logic [DATA_W:0]   y_q_a_i,
    input  logic [DATA_W:0]   y_q_b_i,
    output logic [ADDR_W-1:0] z_addr_a_o,
    output logic [ADDR_W-1:0] z_addr_b_o,
    input  logic [DATA_W:0]   z_q_a_i,
    input  logic [DATA_W:0]   z_q_b_i,
    output logic [ADDR_W-1:0] w_addr_a_o,
    output logic [ADDR_W-1:0] w_addr_b_o,
    output logic [DATA_W-1:0] w_data_a_o,
    output logic [DATA_W-1:0] w_data_b_o,
    output logic              w_wren_o,
    output logic [ADDR_W-1:0] x_addr_a_o,
    output logic [ADDR_W-1:0] x_addr_b_o,
    output logic [DATA_W-1:0] x_data_a_o,
    output logic [DATA_W-1:0] x_data_b_o,
    output logic              x_wren_o,
    output logic [ADDR_W:0]   par_err_cnt_o
);
    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

    localparam int EXT_W = DATA_W + 2;
    localparam int CNT_W = ADDR_W + 1;
    localparam int DRN_W = $clog2(RD_LAT + 2);
    localparam logic [ADDR_W-1:0] K_LAST   = ADDR_W'(HALF - 1);
    localparam logic [ADDR_W-1:0] K_OFS    = ADDR_W'(HALF);
    localparam logic [DRN_W-1:0]  DRN_LAST = DRN_W'(RD_LAT);

    state_t             state, state_nxt;
    logic [ADDR_W-1:0]  k;
    logic [DRN_W-1:0]   drn_cnt;
    logic               issue;
    logic [RD_LAT-1:0]  vld_sr;
    logic [ADDR_W-1:0]  k_sr [RD_LAT];
    logic               wr_vld;
    logic [ADDR_W-1:0]  wr_addr_a, wr_addr_b;
    logic [CNT_W-1:0]   par_err_cnt;

    logic signed [EXT_W-1:0] ya_ext, yb_ext, za_ext, zb_ext;
    logic signed [EXT_W-1:0] s_w0, s_w1, s_x0, s_x1;
    logic                    unused_bits;

    always_ff @(posedge CLOCK_50_I or negedge resetn) begin
        if (!resetn) state <= S_IDLE;
        else         state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            S_IDLE:  if (start_i) state_nxt = S_RUN;
            S_RUN:   if (k == K_LAST) state_nxt = S_DRAIN;
            S_DRAIN: if (drn_cnt == DRN_LAST) state_nxt = S_DONE;
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        busy_o = 1'b0;
        done_o = 1'b0;
        issue  = 1'b0;
        unique case (state)
            S_RUN:   begin busy_o = 1'b1; issue = 1'b1; end
            S_DRAIN: busy_o = 1'b1;
            S_DONE:  begin busy_o = 1'b1; done_o = 1'b1; end
            default: ;
        endcase
    end

    // Read addresses are driven only while issuing so idle/reset outputs stay at 0.
    assign y_addr_a_o = issue ? k : '0;
    assign y_addr_b_o = issue ? (k + K_OFS) : '0;
    assign z_addr_a_o = issue ? k : '0;
    assign z_addr_b_o = issue ? (k + K_OFS) : '0;

    always_ff @(posedge CLOCK_50_I or negedge resetn) begin
        if (!resetn) begin
            k       <= '0;
            drn_cnt <= '0;
        end else begin
            unique case (state)
                S_IDLE:  begin k <= '0; drn_cnt <= '0; end
                S_RUN:   k <= k + ADDR_W'(1);
                S_DRAIN: drn_cnt <= drn_cnt + DRN_W'(1);
                default: ;
            endcase
        end
    end

    // Carries the pair index alongside the RAM read latency.
    always_ff @(posedge CLOCK_50_I or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < RD_LAT; i++) begin
                vld_sr[i] <= 1'b0;
                k_sr[i]   <= '0;
            end
        end else begin
            vld_sr[0] <= issue;
            k_sr[0]   <= k;
            for (int i = 1; i < RD_LAT; i++) begin
                vld_sr[i] <= vld_sr[i-1];
                k_sr[i]   <= k_sr[i-1];
            end
        end
    end

    assign ya_ext = {y_q_a_i[DATA_W], y_q_a_i};
    assign yb_ext = {y_q_b_i[DATA_W], y_q_b_i};
    assign za_ext = {1'b0, z_q_a_i};
    assign zb_ext = {1'b0, z_q_b_i};
    assign s_w0   = za_ext + yb_ext;
    assign s_x1   = za_ext - yb_ext;
    assign s_w1   = zb_ext + ya_ext;
    assign s_x0   = zb_ext - ya_ext;
    // Only the W sums carry the parity information; X LSBs always equal them.
    assign unused_bits = ^{s_w0[EXT_W-1], s_w1[EXT_W-1], s_x0[EXT_W-1], s_x0[0],
                           s_x1[EXT_W-1], s_x1[0]};

    always_ff @(posedge CLOCK_50_I or negedge resetn) begin
        if (!resetn) begin
            wr_vld      <= 1'b0;
            wr_addr_a   <= '0;
            wr_addr_b   <= '0;
            w_data_a_o  <= '0;
            w_data_b_o  <= '0;
            x_data_a_o  <= '0;
            x_data_b_o  <= '0;
            par_err_cnt <= '0;
        end else begin
            wr_vld <= vld_sr[RD_LAT-1];
            if (state == S_IDLE && start_i) par_err_cnt <= '0;
            if (vld_sr[RD_LAT-1]) begin
                wr_addr_a   <= k_sr[RD_LAT-1];
                wr_addr_b   <= k_sr[RD_LAT-1] + K_OFS;
                w_data_a_o  <= s_w0[DATA_W:1];
                w_data_b_o  <= s_w1[DATA_W:1];
                x_data_a_o  <= s_x0[DATA_W:1];
                x_data_b_o  <= s_x1[DATA_W:1];
                par_err_cnt <= par_err_cnt + CNT_W'(s_w0[0]) + CNT_W'(s_w1[0]);
            end
        end
    end

    assign w_wren_o      = wr_vld;
    assign x_wren_o      = wr_vld;
    assign w_addr_a_o    = wr_addr_a;
    assign w_addr_b_o    = wr_addr_b;
    assign x_addr_a_o    = wr_addr_a;
    assign x_addr_b_o    = wr_addr_b;
    assign par_err_cnt_o = par_err_cnt;
endmodule

// File: tb/tb_butterfly_decoder.sv
// Bench for butterfly_decoder: RAM models for RD_LAT=1 and RD_LAT=2 instances, an arithmetic
// reference of the decode, and a per-cycle comparison of every output against the run timeline.
module tb_butterfly_decoder;
    localparam int H = 256;
    localparam int N = 512;

    logic CLOCK_50_I = 1'b0;
    logic resetn = 1'b0;
    always #5 CLOCK_50_I = ~CLOCK_50_I;

    logic       start [2];
    logic       busy [2], done [2], wwr [2], xwr [2];
    logic [8:0] yaa [2], yab [2], zaa [2], zab [2];
    logic [8:0] waa [2], wab [2], xaa [2], xab [2];
    logic [7:0] wda [2], wdb [2], xda [2], xdb [2];
    logic [8:0] yqa [2], yqb [2], zqa [2], zqb [2];
    logic [8:0] p_ya, p_yb, p_za, p_zb;
    logic [9:0] cnt [2];

    logic [8:0] ymem [N];
    logic [8:0] zmem [N];
    int srcw [N], srcx [N], expw [N], expx [N];
    int expcnt;
    int checks = 0;
    int fails = 0;

    butterfly_decoder #(.RD_LAT(1)) dut1 (
        .CLOCK_50_I(CLOCK_50_I), .resetn(resetn), .start_i(start[0]),
        .busy_o(busy[0]), .done_o(done[0]),
        .y_addr_a_o(yaa[0]), .y_addr_b_o(yab[0]), .y_q_a_i(yqa[0]), .y_q_b_i(yqb[0]),
        .z_addr_a_o(zaa[0]), .z_addr_b_o(zab[0]), .z_q_a_i(zqa[0]), .z_q_b_i(zqb[0]),
        .w_addr_a_o(waa[0]), .w_addr_b_o(wab[0]), .w_data_a_o(wda[0]), .w_data_b_o(wdb[0]),
        .w_wren_o(wwr[0]),
        .x_addr_a_o(xaa[0]), .x_addr_b_o(xab[0]), .x_data_a_o(xda[0]), .x_data_b_o(xdb[0]),
        .x_wren_o(xwr[0]), .par_err_cnt_o(cnt[0]));

    butterfly_decoder #(.RD_LAT(2)) dut2 (
        .CLOCK_50_I(CLOCK_50_I), .resetn(resetn), .start_i(start[1]),
        .busy_o(busy[1]), .done_o(done[1]),
        .y_addr_a_o(yaa[1]), .y_addr_b_o(yab[1]), .y_q_a_i(yqa[1]), .y_q_b_i(yqb[1]),
        .z_addr_a_o(zaa[1]), .z_addr_b_o(zab[1]), .z_q_a_i(zqa[1]), .z_q_b_i(zqb[1]),
        .w_addr_a_o(waa[1]), .w_addr_b_o(wab[1]), .w_data_a_o(wda[1]), .w_data_b_o(wdb[1]),
        .w_wren_o(wwr[1]),
        .x_addr_a_o(xaa[1]), .x_addr_b_o(xab[1]), .x_data_a_o(xda[1]), .x_data_b_o(xdb[1]),
        .x_wren_o(xwr[1]), .par_err_cnt_o(cnt[1]));

    always @(posedge CLOCK_50_I) begin
        yqa[0] <= ymem[yaa[0]];
        yqb[0] <= ymem[yab[0]];
        zqa[0] <= zmem[zaa[0]];
        zqb[0] <= zmem[zab[0]];
        p_ya   <= ymem[yaa[1]];
        p_yb   <= ymem[yab[1]];
        p_za   <= zmem[zaa[1]];
        p_zb   <= zmem[zab[1]];
        yqa[1] <= p_ya;
        yqb[1] <= p_yb;
        zqa[1] <= p_za;
        zqb[1] <= p_zb;
    end

    task automatic chk(input string nm, input int act, input int req);
        checks++;
        if (act != req) begin
            fails++;
            $display("FAIL %s actual=%0d required=%0d", nm, act, req);
        end
    endtask

    function automatic int outs_or(input int s);
        return int'(|{busy[s], done[s], wwr[s], xwr[s], yaa[s], yab[s], zaa[s], zab[s],
                      waa[s], wab[s], wda[s], wdb[s], xaa[s], xab[s], xda[s], xdb[s], cnt[s]});
    endfunction

    task automatic encode();
        for (int i = 0; i < H; i++) begin
            ymem[i]     = 9'(srcw[i+H] - srcx[i]);
            ymem[i+H]   = 9'(srcw[i] - srcx[i+H]);
            zmem[i]     = 9'(srcw[i] + srcx[i+H]);
            zmem[i+H]   = 9'(srcw[i+H] + srcx[i]);
        end
    endtask

    // Reference decode straight from the pairing identities, in plain integers.
    task automatic model();
        int ya, yb, za, zb, sw0, sw1, sx0, sx1;
        expcnt = 0;
        for (int i = 0; i < H; i++) begin
            ya = $signed(ymem[i]);
            yb = $signed(ymem[i+H]);
            za = int'(zmem[i]);
            zb = int'(zmem[i+H]);
            sw0 = za + yb;
            sx1 = za - yb;
            sw1 = zb + ya;
            sx0 = zb - ya;
            expw[i]   = (sw0 >>> 1) & 255;
            expw[i+H] = (sw1 >>> 1) & 255;
            expx[i]   = (sx0 >>> 1) & 255;
            expx[i+H] = (sx1 >>> 1) & 255;
            expcnt += (sw0 & 1) + (sw1 & 1);
        end
    endtask

    function automatic int mism_src();
        int m = 0;
        for (int i = 0; i < N; i++)
            if (expw[i] != srcw[i] || expx[i] != srcx[i]) m++;
        return m;
    endfunction

    task automatic load_ramp();
        for (int i = 0; i < N; i++) begin
            srcw[i] = i & 255;
            srcx[i] = 255 - (i & 255);
        end
        encode();
        model();
    endtask

    // n counts cycles from T0 (the cycle in which start is sampled).
    task automatic cyc_chk(input int n, input int s, input int lat);
        bit eb, ed, ew, ok;
        int k, ea, eda, exa;
        eb = (n >= 1) && (n <= 2 + H + lat);
        ed = (n == 2 + H + lat);
        ew = (n >= 2 + lat) && (n <= 1 + lat + H);
        k = n - 2 - lat;
        ea = ew ? k : 0;
        eda = ew ? expw[k] : 0;
        exa = ew ? expx[k] : 0;
        ok = (busy[s] === eb) && (done[s] === ed) && (wwr[s] === ew) && (xwr[s] === ew);
        if (ew)
            ok = ok && int'(waa[s]) == k && int'(wab[s]) == k + H &&
                 int'(xaa[s]) == k && int'(xab[s]) == k + H &&
                 int'(wda[s]) == expw[k] && int'(wdb[s]) == expw[k+H] &&
                 int'(xda[s]) == expx[k] && int'(xdb[s]) == expx[k+H];
        if (n >= 1 && n <= H)
            ok = ok && int'(yaa[s]) == n - 1 && int'(yab[s]) == n - 1 + H &&
                 int'(zaa[s]) == n - 1 && int'(zab[s]) == n - 1 + H;
        checks++;
        if (!ok) begin
            fails++;
            $display("FAIL cycle T0+%0d dut%0d: busy=%b done=%b wren=%b wa=%0d wd=%0d xd=%0d ya=%0d required busy=%b done=%b wren=%b wa=%0d wd=%0d xd=%0d",
                     n, s, busy[s], done[s], wwr[s], waa[s], wda[s], xda[s], yaa[s],
                     eb, ed, ew, ea, eda, exa);
        end
    endtask

    // Entered just after a falling edge; that cycle becomes T0.
    task automatic run(input int s, input bit hold, input int pulse_n, input int abort_n);
        int lat, last;
        lat = s + 1;
        last = 2 + H + lat;
        start[s] = 1'b1;
        cyc_chk(0, s, lat);
        for (int n = 1; n <= last; n++) begin
            @(negedge CLOCK_50_I);
            if (n == 1 && !hold) start[s] = 1'b0;
            if (n == pulse_n) start[s] = 1'b1;
            if (n == pulse_n + 1 && !hold) start[s] = 1'b0;
            if (n == abort_n) begin
                resetn = 1'b0;
                start[s] = 1'b0;
                #1;
                chk("abort_outputs_cleared", outs_or(s), 0);
                @(negedge CLOCK_50_I);
                resetn = 1'b1;
                return;
            end
            cyc_chk(n, s, lat);
        end
        if (!hold) begin
            @(negedge CLOCK_50_I);
            cyc_chk(last + 1, s, lat);
        end
    endtask

    initial begin
        start[0] = 1'b0;
        start[1] = 1'b0;
        repeat (3) @(negedge CLOCK_50_I);
        chk("reset_outputs_dut1", outs_or(0), 0);
        chk("reset_outputs_dut2", outs_or(1), 0);
        resetn = 1'b1;
        repeat (2) @(negedge CLOCK_50_I);
        chk("idle_outputs_dut1", outs_or(0), 0);

        // Ramp data
        load_ramp();
        chk("pin_y0", $signed(ymem[0]), -255);
        chk("pin_z0", int'(zmem[0]), 255);
        chk("model_ramp_exact", mism_src(), 0);
        run(0, 1'b0, -1, -1);
        chk("par_cnt_ramp", int'(cnt[0]), 0);

        // Extreme values
        for (int i = 0; i < N; i++) begin srcw[i] = 255; srcx[i] = 0; end
        encode();
        model();
        chk("pin_y_pos255", $signed(ymem[3]), 255);
        chk("model_w255_exact", mism_src(), 0);
        repeat (3) @(negedge CLOCK_50_I);
        run(0, 1'b0, -1, -1);
        chk("par_cnt_w255", int'(cnt[0]), 0);
        for (int i = 0; i < N; i++) begin srcw[i] = 0; srcx[i] = 255; end
        encode();
        model();
        chk("pin_y_neg255", $signed(ymem[300]), -255);
        chk("model_x255_exact", mism_src(), 0);
        repeat (3) @(negedge CLOCK_50_I);
        run(0, 1'b0, -1, -1);
        chk("par_cnt_x255", int'(cnt[0]), 0);

        // Corrupted Z[5] LSB
        load_ramp();
        zmem[5] = zmem[5] ^ 9'd1;
        model();
        chk("pin_w5_corrupt", expw[5], 4);
        chk("pin_x261_corrupt", expx[261], 249);
        chk("pin_cnt_corrupt", expcnt, 1);
        chk("pin_only_two_words_off", mism_src(), 2);
        repeat (3) @(negedge CLOCK_50_I);
        run(0, 1'b0, -1, -1);
        repeat (4) @(negedge CLOCK_50_I);
        chk("par_cnt_corrupt_held", int'(cnt[0]), 1);

        // Start pulse mid-run, then back-to-back runs with start held
        load_ramp();
        run(0, 1'b0, 100, -1);
        chk("par_cnt_cleared_on_start", int'(cnt[0]), 0);
        repeat (3) @(negedge CLOCK_50_I);
        run(0, 1'b1, -1, -1);
        @(negedge CLOCK_50_I);
        run(0, 1'b0, -1, -1);

        // Reset mid-run, then a clean full run
        repeat (3) @(negedge CLOCK_50_I);
        run(0, 1'b0, -1, 50);
        repeat (2) @(negedge CLOCK_50_I);
        run(0, 1'b0, -1, -1);
        chk("par_cnt_after_abort", int'(cnt[0]), 0);

        // Two-cycle RAM latency, corrupted data to exercise parity there too
        zmem[300] = zmem[300] ^ 9'd1;
        model();
        repeat (3) @(negedge CLOCK_50_I);
        run(1, 1'b0, -1, -1);
        chk("par_cnt_lat2", int'(cnt[1]), expcnt);
        chk("dut1_idle_during_lat2", int'(busy[0]), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end
endmodule
